// File: rtl/code_lock_pkg.sv
// rtl/code_lock_pkg.sv - state encoding and state_leds constants for the code lock
package code_lock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b000,
        ST_ENTRY    = 3'b001,
        ST_CHECK    = 3'b010,
        ST_UNLOCKED = 3'b011,
        ST_ERROR    = 3'b100,
        ST_LOCKOUT  = 3'b101,
        ST_PROGRAM  = 3'b110
    } state_t;

    localparam logic [2:0] LEDS_IDLE     = 3'b000;
    localparam logic [2:0] LEDS_ENTRY    = 3'b001;
    localparam logic [2:0] LEDS_CHECK    = 3'b010;
    localparam logic [2:0] LEDS_UNLOCKED = 3'b011;
    localparam logic [2:0] LEDS_ERROR    = 3'b100;
    localparam logic [2:0] LEDS_LOCKOUT  = 3'b101;
    localparam logic [2:0] LEDS_PROGRAM  = 3'b110;

    // Map a state onto its front-panel code; unused encodings show as idle.
    function automatic logic [2:0] state_to_leds(state_t s);
        logic [2:0] leds;
        case (s)
            ST_IDLE:     leds = LEDS_IDLE;
            ST_ENTRY:    leds = LEDS_ENTRY;
            ST_CHECK:    leds = LEDS_CHECK;
            ST_UNLOCKED: leds = LEDS_UNLOCKED;
            ST_ERROR:    leds = LEDS_ERROR;
            ST_LOCKOUT:  leds = LEDS_LOCKOUT;
            ST_PROGRAM:  leds = LEDS_PROGRAM;
            default:     leds = LEDS_IDLE;
        endcase
        return leds;
    endfunction

endpackage

// File: rtl/code_lock_param_btn_rise.sv
// rtl/code_lock_param_btn_rise.sv - registered rising-edge detector for one button
module btn_rise (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic rise_o
);

    logic prev_q;

    // Remember last cycle's button level so a held button fires only once.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= btn_i;
        end
    end

    assign rise_o = btn_i & ~prev_q;

endmodule

// File: rtl/code_lock_param.sv
// rtl/code_lock_param.sv - parametrised digit code lock with lockout, timeout, relock and reprogramming
module code_lock_param
    import code_lock_pkg::*;
#(
    parameter int DIGIT_W        = 4,
    parameter int CODE_LEN       = 4,
    parameter logic [DIGIT_W*CODE_LEN-1:0] DEFAULT_CODE = 16'h1234,
    parameter int MAX_TRIES      = 3,
    parameter int ERR_CYCLES     = 8,
    parameter int LOCKOUT_CYCLES = 64,
    parameter int ENTRY_TIMEOUT  = 32,
    parameter int RELOCK_CYCLES  = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DIGIT_W-1:0]             in_digit,
    input  logic                           enter_btn,
    input  logic                           lock_btn,
    input  logic                           prog_btn,
    output logic                           locked_led,
    output logic                           unlocked_led,
    output logic                           error_led,
    output logic                           lockout_led,
    output logic [2:0]                     state_leds,
    output logic [$clog2(MAX_TRIES+1)-1:0] tries_left
);

    localparam int CW  = DIGIT_W * CODE_LEN;
    localparam int IW  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int TW  = $clog2(MAX_TRIES + 1);
    localparam int EW  = $clog2(ERR_CYCLES + 1);
    localparam int LW  = $clog2(LOCKOUT_CYCLES + 1);
    localparam int NW  = $clog2(ENTRY_TIMEOUT + 1);
    localparam int RW  = (RELOCK_CYCLES > 0) ? $clog2(RELOCK_CYCLES + 1) : 1;

    localparam logic [IW-1:0] IDX_LAST  = IW'(CODE_LEN - 1);
    localparam logic [TW-1:0] TRIES_MAX = TW'(MAX_TRIES);
    localparam logic [EW-1:0] ERR_LAST  = EW'(ERR_CYCLES - 1);
    localparam logic [EW-1:0] ERR_SAT   = EW'(ERR_CYCLES);
    localparam logic [LW-1:0] LCK_LAST  = LW'(LOCKOUT_CYCLES - 1);
    localparam logic [LW-1:0] LCK_SAT   = LW'(LOCKOUT_CYCLES);
    localparam logic [NW-1:0] ENT_LAST  = NW'(ENTRY_TIMEOUT - 1);
    localparam logic [NW-1:0] ENT_SAT   = NW'(ENTRY_TIMEOUT);
    localparam logic [RW-1:0] REL_LAST  = (RELOCK_CYCLES > 0) ? RW'(RELOCK_CYCLES - 1) : '0;
    localparam logic [RW-1:0] REL_SAT   = (RELOCK_CYCLES > 0) ? RW'(RELOCK_CYCLES) : '0;

    logic enter_rise;
    logic lock_rise;
    logic prog_rise;

    btn_rise u_enter_rise (.clk(clk), .reset(reset), .btn_i(enter_btn), .rise_o(enter_rise));
    btn_rise u_lock_rise  (.clk(clk), .reset(reset), .btn_i(lock_btn),  .rise_o(lock_rise));
    btn_rise u_prog_rise  (.clk(clk), .reset(reset), .btn_i(prog_btn),  .rise_o(prog_rise));

    state_t        state_q, state_d;
    logic [CW-1:0] code_q,  code_d;
    logic [CW-1:0] buf_q,   buf_d;
    logic [IW-1:0] idx_q,   idx_d;
    logic [TW-1:0] fail_q,  fail_d;
    logic [EW-1:0] err_tmr_q,    err_tmr_d;
    logic [LW-1:0] lck_tmr_q,    lck_tmr_d;
    logic [NW-1:0] ent_tmr_q,    ent_tmr_d;
    logic [RW-1:0] rel_tmr_q,    rel_tmr_d;

    logic          locked_led_q;
    logic          unlocked_led_q;
    logic          error_led_q;
    logic          lockout_led_q;
    logic [2:0]    state_leds_q;
    logic [TW-1:0] tries_left_q;

    logic [CW-1:0] buf_ins;
    logic [TW-1:0] fail_inc;

    // The entry buffer doubles as the shadow buffer while programming; MSB digit is index 0.
    always_comb begin
        buf_ins = buf_q;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (idx_q == IW'(i)) begin
                buf_ins[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W] = in_digit;
            end
        end
    end

    assign fail_inc = fail_q + TW'(1);

    // Next-state logic; each timer clears whenever its state is not active.
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        buf_d     = buf_q;
        idx_d     = idx_q;
        fail_d    = fail_q;
        err_tmr_d = '0;
        lck_tmr_d = '0;
        ent_tmr_d = '0;
        rel_tmr_d = '0;

        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (enter_rise) begin
                    buf_d = buf_ins;
                    if (CODE_LEN == 1) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_ENTRY;
                        idx_d   = IW'(1);
                    end
                end
            end

            ST_ENTRY: begin
                if (enter_rise) begin
                    buf_d = buf_ins;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_CHECK;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else if (ent_tmr_q == ENT_LAST) begin
                    // Abandoned entry: discard the partial code without counting a failure.
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    ent_tmr_d = (ent_tmr_q == ENT_SAT) ? ent_tmr_q : ent_tmr_q + NW'(1);
                end
            end

            ST_CHECK: begin
                idx_d = '0;
                if (buf_q == code_q) begin
                    state_d = ST_UNLOCKED;
                    fail_d  = '0;
                end else begin
                    fail_d  = fail_inc;
                    state_d = (fail_inc == TRIES_MAX) ? ST_LOCKOUT : ST_ERROR;
                end
            end

            ST_ERROR: begin
                if (err_tmr_q == ERR_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    err_tmr_d = (err_tmr_q == ERR_SAT) ? err_tmr_q : err_tmr_q + EW'(1);
                end
            end

            ST_LOCKOUT: begin
                if (lck_tmr_q == LCK_LAST) begin
                    state_d = ST_IDLE;
                    fail_d  = '0;
                end else begin
                    lck_tmr_d = (lck_tmr_q == LCK_SAT) ? lck_tmr_q : lck_tmr_q + LW'(1);
                end
            end

            ST_UNLOCKED: begin
                idx_d = '0;
                if (lock_rise) begin
                    state_d = ST_IDLE;
                end else if (prog_rise) begin
                    state_d = ST_PROGRAM;
                end else if (RELOCK_CYCLES > 0) begin
                    if (enter_rise) begin
                        rel_tmr_d = '0;
                    end else if (rel_tmr_q == REL_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        rel_tmr_d = (rel_tmr_q == REL_SAT) ? rel_tmr_q : rel_tmr_q + RW'(1);
                    end
                end
            end

            ST_PROGRAM: begin
                if (lock_rise) begin
                    // Abort leaves the stored code untouched.
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else if (enter_rise) begin
                    buf_d = buf_ins;
                    if (idx_q == IDX_LAST) begin
                        code_d  = buf_ins;
                        state_d = ST_UNLOCKED;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // State, datapath and Moore output registers; outputs decode the next state so they track state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            code_q         <= DEFAULT_CODE;
            buf_q          <= '0;
            idx_q          <= '0;
            fail_q         <= '0;
            err_tmr_q      <= '0;
            lck_tmr_q      <= '0;
            ent_tmr_q      <= '0;
            rel_tmr_q      <= '0;
            locked_led_q   <= 1'b1;
            unlocked_led_q <= 1'b0;
            error_led_q    <= 1'b0;
            lockout_led_q  <= 1'b0;
            state_leds_q   <= LEDS_IDLE;
            tries_left_q   <= TRIES_MAX;
        end else begin
            state_q        <= state_d;
            code_q         <= code_d;
            buf_q          <= buf_d;
            idx_q          <= idx_d;
            fail_q         <= fail_d;
            err_tmr_q      <= err_tmr_d;
            lck_tmr_q      <= lck_tmr_d;
            ent_tmr_q      <= ent_tmr_d;
            rel_tmr_q      <= rel_tmr_d;
            locked_led_q   <= !(state_d == ST_UNLOCKED || state_d == ST_PROGRAM);
            unlocked_led_q <=  (state_d == ST_UNLOCKED || state_d == ST_PROGRAM);
            error_led_q    <=  (state_d == ST_ERROR || state_d == ST_LOCKOUT);
            lockout_led_q  <=  (state_d == ST_LOCKOUT);
            state_leds_q   <= state_to_leds(state_d);
            tries_left_q   <= TRIES_MAX - fail_d;
        end
    end

    assign locked_led   = locked_led_q;
    assign unlocked_led = unlocked_led_q;
    assign error_led    = error_led_q;
    assign lockout_led  = lockout_led_q;
    assign state_leds   = state_leds_q;
    assign tries_left   = tries_left_q;

endmodule

// File: tb/tb_code_lock_param.sv
// tb/tb_code_lock_param.sv - directed self-checking bench for code_lock_param
module tb_code_lock_param;

    logic       clk;
    logic       reset;
    logic [3:0] in_digit;
    logic       enter_btn;
    logic       lock_btn;
    logic       prog_btn;

    logic       locked_led, unlocked_led, error_led, lockout_led;
    logic [2:0] state_leds;
    logic [1:0] tries_left;

    logic       r_locked_led, r_unlocked_led, r_error_led, r_lockout_led;
    logic [2:0] r_state_leds;
    logic [1:0] r_tries_left;

    int checks;
    int failures;

    code_lock_param dut (
        .clk(clk), .reset(reset), .in_digit(in_digit),
        .enter_btn(enter_btn), .lock_btn(lock_btn), .prog_btn(prog_btn),
        .locked_led(locked_led), .unlocked_led(unlocked_led),
        .error_led(error_led), .lockout_led(lockout_led),
        .state_leds(state_leds), .tries_left(tries_left)
    );

    code_lock_param #(.RELOCK_CYCLES(16)) dut_r (
        .clk(clk), .reset(reset), .in_digit(in_digit),
        .enter_btn(enter_btn), .lock_btn(lock_btn), .prog_btn(prog_btn),
        .locked_led(r_locked_led), .unlocked_led(r_unlocked_led),
        .error_led(r_error_led), .lockout_led(r_lockout_led),
        .state_leds(r_state_leds), .tries_left(r_tries_left)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enter_btn = 1'b0; lock_btn = 1'b0; prog_btn = 1'b0; in_digit = 4'h0;
        tick_n(2);
        reset = 1'b0;
    endtask

    task automatic press_digit(input logic [3:0] d);
        in_digit = d;
        enter_btn = 1'b1;
        tick();
        enter_btn = 1'b0;
        tick();
    endtask

    task automatic enter_code(input logic [15:0] c);
        for (int i = 0; i < 4; i++) press_digit(c[15-4*i -: 4]);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enter_btn = 1'b0; lock_btn = 1'b0; prog_btn = 1'b0; in_digit = 4'h0;
        tick_n(2);
        checks++; if (locked_led !== 1'b1)   begin failures++; $display("FAIL reset_locked got=%b exp=1", locked_led); end
        checks++; if (unlocked_led !== 1'b0) begin failures++; $display("FAIL reset_unlocked got=%b exp=0", unlocked_led); end
        checks++; if (error_led !== 1'b0)    begin failures++; $display("FAIL reset_error got=%b exp=0", error_led); end
        checks++; if (lockout_led !== 1'b0)  begin failures++; $display("FAIL reset_lockout got=%b exp=0", lockout_led); end
        checks++; if (state_leds !== 3'b000) begin failures++; $display("FAIL reset_state got=%b exp=000", state_leds); end
        checks++; if (tries_left !== 2'd3)   begin failures++; $display("FAIL reset_tries got=%0d exp=3", tries_left); end
        reset = 1'b0;
    endtask

    task automatic test_unlock();
        do_reset();
        press_digit(4'h1); press_digit(4'h2); press_digit(4'h3);
        checks++; if (state_leds !== 3'b001) begin failures++; $display("FAIL unlock_entry got=%b exp=001", state_leds); end
        in_digit = 4'h4; enter_btn = 1'b1;
        tick();
        checks++; if (state_leds !== 3'b010) begin failures++; $display("FAIL unlock_check got=%b exp=010", state_leds); end
        enter_btn = 1'b0;
        tick();
        checks++; if (state_leds !== 3'b011) begin failures++; $display("FAIL unlock_state got=%b exp=011", state_leds); end
        checks++; if (unlocked_led !== 1'b1 || locked_led !== 1'b0) begin failures++; $display("FAIL unlock_leds got=%b%b exp=10", unlocked_led, locked_led); end
        checks++; if (tries_left !== 2'd3)   begin failures++; $display("FAIL unlock_tries got=%0d exp=3", tries_left); end
    endtask

    task automatic test_lockout();
        do_reset();
        enter_code(16'h1235);
        checks++; if (state_leds !== 3'b100 || error_led !== 1'b1) begin failures++; $display("FAIL err1_state got=%b/%b exp=100/1", state_leds, error_led); end
        checks++; if (tries_left !== 2'd2) begin failures++; $display("FAIL err1_tries got=%0d exp=2", tries_left); end
        tick_n(7);
        checks++; if (state_leds !== 3'b100) begin failures++; $display("FAIL err1_hold got=%b exp=100", state_leds); end
        tick();
        checks++; if (state_leds !== 3'b000) begin failures++; $display("FAIL err1_exit got=%b exp=000", state_leds); end
        enter_code(16'h1235);
        checks++; if (tries_left !== 2'd1) begin failures++; $display("FAIL err2_tries got=%0d exp=1", tries_left); end
        tick_n(8);
        enter_code(16'h1235);
        checks++; if (state_leds !== 3'b101 || lockout_led !== 1'b1 || error_led !== 1'b1) begin failures++; $display("FAIL lockout_state got=%b/%b/%b exp=101/1/1", state_leds, lockout_led, error_led); end
        checks++; if (tries_left !== 2'd0) begin failures++; $display("FAIL lockout_tries got=%0d exp=0", tries_left); end
        enter_code(16'h1234);
        tick_n(55);
        checks++; if (state_leds !== 3'b101) begin failures++; $display("FAIL lockout_hold got=%b exp=101", state_leds); end
        tick();
        checks++; if (state_leds !== 3'b000 || lockout_led !== 1'b0) begin failures++; $display("FAIL lockout_exit got=%b/%b exp=000/0", state_leds, lockout_led); end
        checks++; if (tries_left !== 2'd3) begin failures++; $display("FAIL lockout_tries_reset got=%0d exp=3", tries_left); end
    endtask

    task automatic test_timeout();
        do_reset();
        press_digit(4'h1); press_digit(4'h2);
        tick_n(30);
        checks++; if (state_leds !== 3'b001) begin failures++; $display("FAIL timeout_hold got=%b exp=001", state_leds); end
        tick();
        checks++; if (state_leds !== 3'b000) begin failures++; $display("FAIL timeout_exit got=%b exp=000", state_leds); end
        checks++; if (tries_left !== 2'd3) begin failures++; $display("FAIL timeout_tries got=%0d exp=3", tries_left); end
        enter_code(16'h1234);
        checks++; if (state_leds !== 3'b011) begin failures++; $display("FAIL timeout_unlock got=%b exp=011", state_leds); end
    endtask

    task automatic test_reprogram();
        do_reset();
        enter_code(16'h1234);
        prog_btn = 1'b1; tick(); prog_btn = 1'b0;
        checks++; if (state_leds !== 3'b110 || unlocked_led !== 1'b1 || locked_led !== 1'b0) begin failures++; $display("FAIL prog_state got=%b/%b/%b exp=110/1/0", state_leds, unlocked_led, locked_led); end
        enter_code(16'h9876);
        checks++; if (state_leds !== 3'b011) begin failures++; $display("FAIL prog_done got=%b exp=011", state_leds); end
        lock_btn = 1'b1; tick(); lock_btn = 1'b0;
        checks++; if (state_leds !== 3'b000) begin failures++; $display("FAIL prog_relock got=%b exp=000", state_leds); end
        enter_code(16'h1234);
        checks++; if (state_leds !== 3'b100) begin failures++; $display("FAIL prog_old_code got=%b exp=100", state_leds); end
        tick_n(8);
        enter_code(16'h9876);
        checks++; if (state_leds !== 3'b011 || tries_left !== 2'd3) begin failures++; $display("FAIL prog_new_code got=%b/%0d exp=011/3", state_leds, tries_left); end
        do_reset();
        enter_code(16'h1234);
        checks++; if (state_leds !== 3'b011) begin failures++; $display("FAIL prog_reset_restore got=%b exp=011", state_leds); end
    endtask

    task automatic test_abort_priority();
        do_reset();
        enter_code(16'h1234);
        prog_btn = 1'b1; tick(); prog_btn = 1'b0; tick();
        press_digit(4'h5); press_digit(4'h5);
        in_digit = 4'h7; lock_btn = 1'b1; enter_btn = 1'b1;
        tick();
        lock_btn = 1'b0; enter_btn = 1'b0;
        checks++; if (state_leds !== 3'b000) begin failures++; $display("FAIL abort_state got=%b exp=000", state_leds); end
        tick();
        enter_code(16'h1234);
        checks++; if (state_leds !== 3'b011) begin failures++; $display("FAIL abort_old_code got=%b exp=011", state_leds); end
        lock_btn = 1'b1; prog_btn = 1'b1;
        tick();
        lock_btn = 1'b0; prog_btn = 1'b0;
        checks++; if (state_leds !== 3'b000) begin failures++; $display("FAIL lock_beats_prog got=%b exp=000", state_leds); end
        tick();
    endtask

    task automatic test_held_and_relock();
        do_reset();
        in_digit = 4'h1; enter_btn = 1'b1;
        tick_n(10);
        enter_btn = 1'b0;
        tick();
        checks++; if (state_leds !== 3'b001) begin failures++; $display("FAIL held_entry got=%b exp=001", state_leds); end
        press_digit(4'h2); press_digit(4'h3); press_digit(4'h4);
        checks++; if (state_leds !== 3'b011) begin failures++; $display("FAIL held_one_digit got=%b exp=011", state_leds); end

        do_reset();
        enter_code(16'h1234);
        tick_n(15);
        checks++; if (r_state_leds !== 3'b011) begin failures++; $display("FAIL relock_hold got=%b exp=011", r_state_leds); end
        tick();
        checks++; if (r_state_leds !== 3'b000 || r_locked_led !== 1'b1) begin failures++; $display("FAIL relock_exit got=%b/%b exp=000/1", r_state_leds, r_locked_led); end
        checks++; if (state_leds !== 3'b011) begin failures++; $display("FAIL no_relock got=%b exp=011", state_leds); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        enter_btn = 1'b0; lock_btn = 1'b0; prog_btn = 1'b0; in_digit = 4'h0;
        test_reset();
        test_unlock();
        test_lockout();
        test_timeout();
        test_reprogram();
        test_abort_priority();
        test_held_and_relock();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/code_lock_param.md
Name: code_lock_param

Overview:
- Parametrised successor to the single-code digit lock core.
- Generalised in digit width, code length, attempt limit and timing.
- Adds lockout after repeated failures, an entry timeout, optional auto-relock, and field reprogramming of the code while unlocked.
- Sits behind the chip-level wrapper: buttons and digits come from dedicated inputs; LEDs and the state code go to dedicated outputs.

Parameters:
- DIGIT_W, 4: bits per entered digit.
- CODE_LEN, 4: digits per code (>=1).
- DEFAULT_CODE, 16'h1234: reset code, DIGIT_W*CODE_LEN bits, MSB digit entered first.
- MAX_TRIES, 3: consecutive failed checks that trigger lockout (>=1).
- ERR_CYCLES, 8: cycles spent in ERROR.
- LOCKOUT_CYCLES, 64: cycles spent in LOCKOUT.
- ENTRY_TIMEOUT, 32: idle cycles in ENTRY before the partial code is discarded.
- RELOCK_CYCLES, 0: cycles in UNLOCKED before auto-relock; 0 disables auto-relock.

Ports:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: synchronous, active-high.
- in_digit, in, DIGIT_W: digit value, sampled on an enter edge.
- enter_btn, in, 1: level; each rising edge submits in_digit.
- lock_btn, in, 1: level; rising edge relocks or aborts programming.
- prog_btn, in, 1: level; rising edge in UNLOCKED starts reprogramming.
- locked_led, out, 1: lock engaged.
- unlocked_led, out, 1: UNLOCKED or PROGRAM.
- error_led, out, 1: ERROR or LOCKOUT.
- lockout_led, out, 1: LOCKOUT only.
- state_leds, out, 3: encoded state.
- tries_left, out, $clog2(MAX_TRIES+1): MAX_TRIES minus the fail count.

Behaviour:
- Button edges
  - Each button has its own registered previous sample. A rise is (current & ~previous), computed from clk-sampled inputs.
  - One action per rise; holding a button high does nothing further.
- State encoding: IDLE=000, ENTRY=001, CHECK=010, UNLOCKED=011, ERROR=100, LOCKOUT=101, PROGRAM=110.
- Outputs
  - All outputs are Moore outputs decoded from registered state and counters.
  - locked_led = 1 in every state except UNLOCKED and PROGRAM.
- Reset values
  - state IDLE, stored code = DEFAULT_CODE, fail_cnt 0, digit index 0, timers 0, edge registers 0.
  - Outputs at reset: locked_led 1, unlocked_led 0, error_led 0, lockout_led 0, state_leds 000, tries_left MAX_TRIES.
  - Reset mid-operation in any state returns all of the above, including restoring DEFAULT_CODE.
- IDLE
  - enter rise: store the digit at index 0.
  - Go to ENTRY, or to CHECK if CODE_LEN==1.
- ENTRY
  - enter rise: store the digit at the current index and increment the index.
  - On the rise that stores digit CODE_LEN-1, go to CHECK.
  - No enter rise for ENTRY_TIMEOUT consecutive cycles: go to IDLE, clear the index, do not count a failure. The timer restarts on every accepted digit.
- CHECK (exactly 1 cycle; buttons ignored)
  - Match: go to UNLOCKED, fail_cnt=0.
  - Mismatch: fail_cnt+1. If the new count equals MAX_TRIES, go to LOCKOUT; else go to ERROR.
- ERROR: ERR_CYCLES cycles, then IDLE. All buttons ignored.
- LOCKOUT: LOCKOUT_CYCLES cycles, then IDLE with fail_cnt=0. All buttons ignored.
- UNLOCKED
  - lock rise: go to IDLE.
  - prog rise: go to PROGRAM, index 0.
  - lock and prog rising in the same cycle: lock wins.
  - If RELOCK_CYCLES>0, go to IDLE after RELOCK_CYCLES cycles with no button rise.
- PROGRAM
  - enter rises fill a shadow buffer.
  - After digit CODE_LEN-1, the stored code is replaced atomically and the state returns to UNLOCKED.
  - lock rise aborts: go to IDLE with the stored code unchanged. If lock and enter rise together, lock wins.
  - No timeout in PROGRAM.
- Widths: the index is $clog2(CODE_LEN) bits (min 1). Each timer is sized to its own parameter and saturates at its terminal count. Comparison is full-width equality.

Decomposition:
- Package code_lock_pkg: state enum with the encoding above, and state_leds constants.
- Sub-module btn_rise: 1-bit registered rising-edge detector with synchronous reset, instantiated three times.
- Timers and the FSM stay in code_lock_param.

Test Plan:
- Unlock:
  - Stimulus: reset, then enter 1,2,3,4 with separate rises.
  - Response: CHECK one cycle after the 4th accepting edge, UNLOCKED (011) on the next; unlocked_led=1, tries_left=3.
- Failures to lockout:
  - Stimulus: enter 1,2,3,5.
  - Response: ERROR for 8 cycles, tries_left=2, then IDLE. Repeat twice more: the 3rd failure enters LOCKOUT (101) with lockout_led=1.
  - Digits entered during LOCKOUT are ignored. After 64 cycles: IDLE, tries_left=3.
- Entry timeout:
  - Stimulus: enter 1,2, then wait 32 cycles.
  - Response: IDLE with tries_left unchanged. Entering 1,2,3,4 afterwards unlocks.
- Reprogram:
  - Stimulus: unlock, prog rise, enter 9,8,7,6.
  - Response: UNLOCKED. lock rise gives IDLE; 1,2,3,4 now fails and 9,8,7,6 unlocks. A reset then restores 1234.
- Abort and priority:
  - Stimulus: in PROGRAM after 2 digits, lock and enter rise in the same cycle.
  - Response: IDLE, old code still valid. In UNLOCKED, lock and prog rising together give IDLE.
- Held button and auto-relock:
  - Stimulus: enter_btn held high for 10 cycles.
  - Response: only one digit accepted.
  - With RELOCK_CYCLES=16: UNLOCKED returns to IDLE after 16 idle cycles.
